// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone GPIO slave with per-pin direction, synchronised input readback,
// atomic set/clear and per-pin edge interrupts.
// Optional macro GPIO_DEBOUNCE_EN inserts a per-pin debounce counter after the synchroniser.
module wb_gpio #(
   parameter int unsigned       WIDTH           = 8,
   parameter int unsigned       SYNC_STAGES     = 2,
   parameter logic [WIDTH-1:0]  RST_OUT         = '0,
   parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_cyc,
   input  logic             wb_stb,
   input  logic             wb_we,
   input  logic [31:0]      wb_adr,
   input  logic [3:0]       wb_sel,
   input  logic [31:0]      wb_dat_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack,
   output logic             wb_stall,
   output logic             wb_err,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic             r_ack;
   logic [31:0]      r_dat;
   logic [WIDTH-1:0] r_out, r_dir, r_en, r_status, r_edge, r_prev;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];

   logic             w_accept, w_wr, w_unused;
   logic [2:0]       w_off;
   logic [31:0]      w_bmask, w_rd;
   logic [WIDTH-1:0] w_m, w_d, w_w1c, w_sync, w_in, w_evt;

   assign w_accept = wb_cyc & wb_stb & ~r_ack;
   assign w_wr     = w_accept & wb_we;
   assign w_off    = wb_adr[4:2];
   assign w_bmask  = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
   assign w_m      = w_bmask[WIDTH-1:0];
   assign w_d      = wb_dat_i[WIDTH-1:0] & w_m;
   assign w_w1c    = (w_wr && w_off == 3'd4) ? w_d : '0;
   // Address bits outside [4:2] and data bits above WIDTH are intentionally ignored.
   assign w_unused = ^{wb_adr[31:5], wb_adr[1:0], wb_dat_i, w_bmask};

   // Input synchroniser chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end
   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned  CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   logic [CntW-1:0]  r_cnt [WIDTH];
   logic [WIDTH-1:0] r_deb;

   // Per-pin debounce: adopt the new level only after it persists DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_deb <= '0;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CntLast) begin
               r_deb[i] <= w_sync[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end
   assign w_in = r_deb;
`else
   assign w_in = w_sync;
`endif

   // Selected edge per pin, gated by its enable.
   assign w_evt = r_en & (((w_in & ~r_prev) & r_edge) | ((~w_in & r_prev) & ~r_edge));

   // Control registers, previous-sample flop and interrupt status (set beats W1C).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out    <= RST_OUT;
         r_dir    <= '0;
         r_en     <= '0;
         r_status <= '0;
         r_edge   <= '0;
         r_prev   <= '0;
      end else begin
         r_prev   <= w_in;
         r_status <= (r_status & ~w_w1c) | w_evt;
         if (w_wr) begin
            case (w_off)
               3'd0:    r_out  <= (r_out & ~w_m) | w_d;
               3'd1:    r_dir  <= (r_dir & ~w_m) | w_d;
               3'd3:    r_en   <= (r_en & ~w_m) | w_d;
               3'd5:    r_edge <= (r_edge & ~w_m) | w_d;
               3'd6:    r_out  <= r_out | w_d;
               3'd7:    r_out  <= r_out & ~w_d;
               default: ;
            endcase
         end
      end
   end

   // Read data mux; SET/CLR and unused upper bits read as zero.
   always_comb begin
      w_rd = '0;
      case (w_off)
         3'd0:    w_rd[WIDTH-1:0] = r_out;
         3'd1:    w_rd[WIDTH-1:0] = r_dir;
         3'd2:    w_rd[WIDTH-1:0] = w_in;
         3'd3:    w_rd[WIDTH-1:0] = r_en;
         3'd4:    w_rd[WIDTH-1:0] = r_status;
         3'd5:    w_rd[WIDTH-1:0] = r_edge;
         default: w_rd = '0;
      endcase
   end

   // Single-cycle ack; read data is held only during the ack cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_accept;
         r_dat <= (w_accept && !wb_we) ? w_rd : '0;
      end
   end

   assign wb_ack   = r_ack;
   assign wb_dat_o = r_dat;
   assign wb_stall = 1'b0;
   assign wb_err   = 1'b0;
   assign gpio_o   = r_out;
   assign gpio_oe  = r_dir;
   assign irq      = |r_status;

endmodule

// File: tb/tb_wb_gpio.sv
// tb_wb_gpio: directed and randomized checks of wb_gpio against a register-level model.
module tb_wb_gpio;

   localparam int unsigned W  = 8;
   localparam int unsigned SS = 2;
   localparam logic [7:0]  RO = 8'hA5;
`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned LAT = SS + 16;
`else
   localparam int unsigned LAT = SS;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [31:0]   wb_adr = '0, wb_dat_i = '0;
   logic [3:0]    wb_sel = '0;
   logic [31:0]   wb_dat_o;
   logic          wb_ack, wb_stall, wb_err, irq;
   logic [W-1:0]  gpio_i = '0;
   logic [W-1:0]  gpio_o, gpio_oe;

   int checks = 0;
   int failures = 0;

   // Register-level model.
   logic [7:0] m_out = RO, m_dir = '0, m_en = '0, m_st = '0, m_edge = '0, m_pins = '0;

   wb_gpio #(
      .WIDTH(W), .SYNC_STAGES(SS), .RST_OUT(RO), .DEBOUNCE_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err), .gpio_i(gpio_i),
      .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] off);
      case (off)
         3'd0:    return {24'h0, m_out};
         3'd1:    return {24'h0, m_dir};
         3'd2:    return {24'h0, m_pins};
         3'd3:    return {24'h0, m_en};
         3'd4:    return {24'h0, m_st};
         3'd5:    return {24'h0, m_edge};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [7:0] m;
      logic [7:0] v;
      m = {8{s[0]}};
      v = d[7:0] & m;
      case (off)
         3'd0: m_out  = (m_out & ~m) | v;
         3'd1: m_dir  = (m_dir & ~m) | v;
         3'd3: m_en   = (m_en & ~m) | v;
         3'd4: m_st   = m_st & ~v;
         3'd5: m_edge = (m_edge & ~m) | v;
         3'd6: m_out  = m_out | v;
         3'd7: m_out  = m_out & ~v;
         default: ;
      endcase
   endtask

   // One Wishbone transfer; ack is required exactly one cycle after the strobe.
   task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
      @(negedge clk);
      check("ack_before", 32'(wb_ack), 32'h0);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
      @(posedge clk); #1;
      check("ack", 32'(wb_ack), 32'h1);
      rd = wb_dat_o;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
      check("ack_drop", 32'(wb_ack), 32'h0);
      check("dat_idle", wb_dat_o, 32'h0);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] rd;
      bus(1'b1, adr, dat, sel, rd);
      model_write(adr[4:2], dat, sel);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] adr);
      logic [31:0] rd;
      bus(1'b0, adr, 32'h0, 4'hF, rd);
      check(tag, rd, model_read(adr[4:2]));
   endtask

   // Change pins and let the change fully propagate; status follows the edge rules.
   task automatic set_pins(input logic [7:0] nv);
      logic [7:0] rise, fall;
      @(negedge clk);
      gpio_i = nv;
      rise = nv & ~m_pins;
      fall = m_pins & ~nv;
      m_st = m_st | (m_en & ((rise & m_edge) | (fall & ~m_edge)));
      m_pins = nv;
      repeat (LAT + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] adr;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_gpio_o", 32'(gpio_o), 32'hA5);
      check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_dat_o", wb_dat_o, 32'h0);
      check("stall_err", {30'h0, wb_stall, wb_err}, 32'h0);
      rd_chk("rst_dir", 32'h4);
      rd_chk("rst_out", 32'h0);

      // Direction, atomic set/clear.
      wr(32'h04, 32'h0F, 4'hF);
      wr(32'h18, 32'h30, 4'hF);
      wr(32'h1C, 32'h05, 4'hF);
      check("oe_0f", 32'(gpio_oe), 32'h0F);
      check("out_b0", 32'(gpio_o), 32'hB0);
      rd_chk("set_reads0", 32'h18);
      rd_chk("clr_reads0", 32'h1C);

      // Back-to-back strobe: acks on alternate cycles.
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h4; wb_sel = 4'hF;
      @(posedge clk); #1; check("b2b_ack1", 32'(wb_ack), 32'h1);
      @(posedge clk); #1; check("b2b_gap", 32'(wb_ack), 32'h0);
      @(posedge clk); #1; check("b2b_ack2", 32'(wb_ack), 32'h1);
      check("b2b_data", wb_dat_o, 32'h0F);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;

      // Upper bits ignored, aliasing inside the window, byte lanes.
      wr(32'h04, 32'hFFFF_FFFF, 4'hF);
      rd_chk("dir_upper0", 32'h104);
      bus(1'b0, 32'h4, 32'h0, 4'hF, rd);
      check("dir_ff", rd, 32'hFF);
      wr(32'h04, 32'h0F, 4'hF);
      wr(32'h00, 32'hFF, 4'h0);
      check("sel0_nochange", 32'(gpio_o), 32'hB0);
      wr(32'h00, 32'h1234_56C3, 4'b0010);
      check("sel_lane1", 32'(gpio_o), 32'hB0);
      wr(32'h00, 32'h1234_56C3, 4'b0001);
      check("sel_lane0", 32'(gpio_o), 32'hC3);

      // Input path.
      set_pins(8'h3C);
      bus(1'b0, 32'h8, 32'h0, 4'hF, rd);
      check("din_3c", rd, 32'h3C);
      wr(32'h08, 32'hFF, 4'hF);
      rd_chk("din_ro", 32'h8);

      // Rising-edge interrupt timing.
      wr(32'h0C, 32'h01, 4'hF);
      wr(32'h14, 32'h01, 4'hF);
      @(negedge clk);
      gpio_i = 8'h3D;
      m_pins = 8'h3D;
      repeat (LAT) @(posedge clk);
      #1;
      check("irq_early", 32'(irq), 32'h0);
      @(posedge clk); #1;
      check("irq_set", 32'(irq), 32'h1);
      m_st = m_st | 8'h01;
      rd_chk("status_01", 32'h10);
      wr(32'h10, 32'h01, 4'hF);
      check("irq_cleared", 32'(irq), 32'(|m_st));
      set_pins(8'h3C);
      check("fall_noirq", 32'(irq), 32'h0);

      // W1C in the same cycle as a new rising edge: set wins.
      @(negedge clk);
      gpio_i = 8'h3D;
      m_pins = 8'h3D;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h10; wb_dat_i = 32'h1;
      wb_sel = 4'hF;
      @(posedge clk); #1;
      check("coll_ack", 32'(wb_ack), 32'h1);
      check("coll_irq", 32'(irq), 32'h1);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      m_st = m_st | 8'h01;
      @(posedge clk); #1;
      rd_chk("coll_status", 32'h10);
      wr(32'h0C, 32'h00, 4'hF);
      rd_chk("en_clear_keeps", 32'h10);
      wr(32'h10, 32'hFF, 4'hF);
      check("irq_off", 32'(irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
      wr(32'h0C, 32'h01, 4'hF);
      set_pins(8'h3C);
      @(negedge clk);
      gpio_i = 8'h3D;
      repeat (10) @(posedge clk);
      @(negedge clk);
      gpio_i = 8'h3C;
      repeat (30) @(posedge clk);
      #1;
      check("glitch_noirq", 32'(irq), 32'h0);
      rd_chk("glitch_din", 32'h8);
      @(negedge clk);
      gpio_i = 8'h3D;
      m_pins = 8'h3D;
      repeat (LAT) @(posedge clk);
      #1;
      check("deb_early", 32'(irq), 32'h0);
      @(posedge clk); #1;
      check("deb_set", 32'(irq), 32'h1);
      m_st = m_st | 8'h01;
      rd_chk("deb_din", 32'h8);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 150; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         adr = {20'h0, 12'($urandom_range(0, 4095))};
         if (r < 4) begin
            wr(adr, $urandom, 4'($urandom_range(0, 15)));
         end else if (r < 8) begin
            rd_chk("rand_read", adr);
         end else begin
            set_pins(8'($urandom));
         end
         check("rand_gpio_o", 32'(gpio_o), 32'(m_out));
         check("rand_gpio_oe", 32'(gpio_oe), 32'(m_dir));
         check("rand_irq", 32'(irq), 32'(|m_st));
      end

      // Reset on the same edge as an accepted strobe drops the ack.
      @(negedge clk);
      rst_n = 1'b0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0;
      @(posedge clk); #1;
      check("rst_ack_drop", 32'(wb_ack), 32'h0);
      check("rst2_gpio_o", 32'(gpio_o), 32'hA5);
      check("rst2_oe", 32'(gpio_oe), 32'h0);
      check("rst2_irq", 32'(irq), 32'h0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
